io_port_hub: RTL and testbench
==============================

IO_PORT_HUB -- requirements
Module: io_port_hub

Interface
REQ-001 SHALL have parameter NUIOIN, default 4, number of processor input ports.
REQ-002 SHALL have parameter NUIOOU, default 4, number of processor output ports.
REQ-003 SHALL have parameter NBIN, default 19, signed input word width.
REQ-004 SHALL have parameter NBOUT, default 28, output word width.
REQ-005 SHALL have parameter FDEPTH, default 4, per-port FIFO depth (power of 2, at least 2).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_in  input  NUIOIN  one-hot read strobe from processor.
REQ-009 SHALL have port io_in  output  NBIN  signed data to processor.
REQ-010 SHALL have port out_en  input  NUIOOU  one-hot write strobe from processor.
REQ-011 SHALL have port io_out  input  NBOUT  data from processor.
REQ-012 SHALL have port src_data  input  NUIOIN*NBIN  producer words, port k at bits [k*NBIN +: NBIN].
REQ-013 SHALL have ports src_valid (input) and src_ready (output), each NUIOIN wide, one valid/ready pair per input port.
REQ-014 SHALL have port snk_data  output  NUIOOU*NBOUT  consumer words, port k at bits [k*NBOUT +: NBOUT].
REQ-015 SHALL have ports snk_valid (output) and snk_ready (input), each NUIOOU wide, one valid/ready pair per output port.
REQ-016 SHALL have port err  output  4  error flags: [0] underflow, [1] overflow, [2] multi-hot req_in, [3] multi-hot out_en.

Function
REQ-017 SHALL keep one FDEPTH-entry FIFO per input port; push when src_valid[k] and src_ready[k] are both high at a clock edge.
REQ-018 SHALL drive src_ready[k] = NOT full[k].
REQ-019 SHALL drive io_in combinationally with the head of FIFO k when req_in[k] is high; io_in SHALL be 0 when no req_in bit is set.
REQ-020 SHALL pop FIFO k at the clock edge where req_in[k] is high and FIFO k is not empty.
REQ-021 SHALL make a pushed word visible at the FIFO head no earlier than the cycle after the push; there is no bypass path.
REQ-022 On req_in[k] with FIFO k empty: io_in = 0, no pop, underflow event.
REQ-023 On multi-hot req_in: serve only the lowest set index; multi-hot-req event.
REQ-024 SHALL keep one FDEPTH-entry FIFO per output port; push io_out at the edge where out_en[k] is high and FIFO k is not full.
REQ-025 On out_en[k] with output FIFO k full: drop the word, leave the FIFO unchanged, overflow event.
REQ-026 On multi-hot out_en: write only the lowest set index; multi-hot-out_en event.
REQ-027 SHALL drive snk_valid[k] = NOT empty[k] and snk_data slice k = head of FIFO k; pop when snk_valid[k] and snk_ready[k] are both high.
REQ-028 SHALL support push and pop on the same FIFO in one cycle when it is neither empty nor full; occupancy is then unchanged.
REQ-029 SHALL wrap read/write pointers modulo FDEPTH and track occupancy with an extra pointer bit.

Reset
REQ-030 SHALL, while rst is low, asynchronously empty all FIFOs and clear all pointers and err.
REQ-031 SHALL hold src_ready all-ones, snk_valid all-zero and io_in = 0 while in reset.
REQ-032 SHALL discard any in-flight handshake when reset asserts mid-transfer; no partial word is retained.

Configuration
REQ-033 With IO_HUB_ERR_EN defined, each err bit SHALL be sticky: set one cycle after its event and cleared only by reset.
REQ-034 Without IO_HUB_ERR_EN, err SHALL be constant 0 and no error logic SHALL be synthesized; the data path is identical in both builds.

Verification
REQ-035 Push 5, -3, 7 on src port 1, then pulse req_in=0010 for 3 cycles -> io_in = 5, -3, 7 in those cycles; src_ready[1] stays 1.
REQ-036 Push 4 words on src port 0 (FDEPTH=4) -> src_ready[0]=0; a 5th src_valid is not accepted; one req_in=0001 pop -> src_ready[0]=1 next cycle.
REQ-037 req_in=0100 with port 2 empty -> io_in=0 and no pop; ERR build: err[0]=1 next cycle and it stays 1.
REQ-038 out_en=1000 with io_out=0x0ABCDEF and snk_ready[3]=0 -> snk_valid[3]=1 with data 0x0ABCDEF; after 4 more writes err[1]=1 and the FIFO still holds the first 4 words.
REQ-039 req_in=0110 with ports 1 and 2 non-empty -> only port 1 is popped; err[2]=1 in the ERR build, err=0 in the non-ERR build.
REQ-040 Drop rst low mid-stream with FIFOs partly full -> all FIFOs empty immediately, snk_valid=0, err=0; after release, the first new push is the first word read out.

Source files
------------

// File: rtl/io_port_hub_if.sv
// io_port_hub_if: processor strobes, producer/consumer valid-ready channels and
// error flags of io_port_hub, bundled into one interface.
// master = processor/producer/consumer side, slave = the hub itself.
interface io_port_hub_if #(
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int NBIN   = 19,
  parameter int NBOUT  = 28
) ();
  logic [NUIOIN-1:0]        req_in;
  logic [NBIN-1:0]          io_in;
  logic [NUIOOU-1:0]        out_en;
  logic [NBOUT-1:0]         io_out;
  logic [NUIOIN*NBIN-1:0]   src_data;
  logic [NUIOIN-1:0]        src_valid;
  logic [NUIOIN-1:0]        src_ready;
  logic [NUIOOU*NBOUT-1:0]  snk_data;
  logic [NUIOOU-1:0]        snk_valid;
  logic [NUIOOU-1:0]        snk_ready;
  logic [3:0]               err;

  modport master (
    output req_in, out_en, io_out, src_data, src_valid, snk_ready,
    input  io_in, src_ready, snk_data, snk_valid, err
  );

  modport slave (
    input  req_in, out_en, io_out, src_data, src_valid, snk_ready,
    output io_in, src_ready, snk_data, snk_valid, err
  );
endinterface

// File: rtl/io_port_hub.sv
// io_port_hub: per-port FIFOs between valid/ready producers/consumers and a
// processor using one-hot read (req_in) and write (out_en) strobes.
// Optional build macro IO_HUB_ERR_EN: sticky error flags on err; without it
// err is tied to zero and no error logic exists.
module io_port_hub #(
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int NBIN   = 19,
  parameter int NBOUT  = 28,
  parameter int FDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  io_port_hub_if.slave    bus
);

  localparam int AW = $clog2(FDEPTH);

  // ---------------- input side (producer -> processor) ----------------
  logic [NUIOIN-1:0] in_full;
  logic [NUIOIN-1:0] in_empty;
  logic [NUIOIN-1:0] in_push;
  logic [NUIOIN-1:0] in_pop;
  logic [NUIOIN-1:0] rd_oh;
  logic [NBIN-1:0]   in_head [NUIOIN];
  logic [NBIN-1:0]   io_in_mux;

  // Lowest set bit of req_in; multi-hot strobes collapse onto it.
  assign rd_oh   = bus.req_in & (~bus.req_in + NUIOIN'(1));
  assign in_push = bus.src_valid & ~in_full;
  assign in_pop  = rd_oh & ~in_empty;

  assign bus.src_ready = ~in_full;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    logic [NBIN-1:0] mem_q [FDEPTH];
    logic [AW:0]     wptr_q;
    logic [AW:0]     rptr_q;

    // Pointer registers; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (in_push[k]) wptr_q <= wptr_q + (AW+1)'(1);
        if (in_pop[k])  rptr_q <= rptr_q + (AW+1)'(1);
      end
    end

    // Storage; contents are only observable through the pointers.
    always_ff @(posedge clk) begin
      if (in_push[k]) mem_q[wptr_q[AW-1:0]] <= bus.src_data[k*NBIN +: NBIN];
    end

    assign in_empty[k] = (wptr_q == rptr_q);
    assign in_full[k]  = (wptr_q[AW] != rptr_q[AW]) &&
                         (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign in_head[k]  = mem_q[rptr_q[AW-1:0]];
  end

  // Read mux: head of the served port, zero when nothing is popped.
  always_comb begin
    io_in_mux = '0;
    for (int unsigned i = 0; i < NUIOIN; i++) begin
      if (in_pop[i]) io_in_mux = in_head[i];
    end
  end

  assign bus.io_in = io_in_mux;

  // ---------------- output side (processor -> consumer) ----------------
  logic [NUIOOU-1:0] out_full;
  logic [NUIOOU-1:0] out_empty;
  logic [NUIOOU-1:0] out_push;
  logic [NUIOOU-1:0] out_pop;
  logic [NUIOOU-1:0] wr_oh;

  assign wr_oh    = bus.out_en & (~bus.out_en + NUIOOU'(1));
  assign out_push = wr_oh & ~out_full;
  assign out_pop  = ~out_empty & bus.snk_ready;

  assign bus.snk_valid = ~out_empty;

  for (genvar k = 0; k < NUIOOU; k++) begin : g_out
    logic [NBOUT-1:0] mem_q [FDEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    // Pointer registers; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (out_push[k]) wptr_q <= wptr_q + (AW+1)'(1);
        if (out_pop[k])  rptr_q <= rptr_q + (AW+1)'(1);
      end
    end

    // Storage written from the processor data bus.
    always_ff @(posedge clk) begin
      if (out_push[k]) mem_q[wptr_q[AW-1:0]] <= bus.io_out;
    end

    assign out_empty[k] = (wptr_q == rptr_q);
    assign out_full[k]  = (wptr_q[AW] != rptr_q[AW]) &&
                          (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign bus.snk_data[k*NBOUT +: NBOUT] = mem_q[rptr_q[AW-1:0]];
  end

  // ---------------- error flags ----------------
`ifdef IO_HUB_ERR_EN
  logic [3:0] err_q;
  logic [3:0] err_d;

  // Accumulate error events; bits only ever set until reset.
  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (|(rd_oh & in_empty));
    err_d[1] = err_q[1] | (|(wr_oh & out_full));
    err_d[2] = err_q[2] | ((bus.req_in & (bus.req_in - NUIOIN'(1))) != '0);
    err_d[3] = err_q[3] | ((bus.out_en & (bus.out_en - NUIOOU'(1))) != '0);
  end

  // Sticky error register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = '0;
`endif

endmodule

// File: tb/tb_io_port_hub.sv
// tb_io_port_hub: scoreboard bench for io_port_hub. Expected words are queued
// when driven and compared when the hub presents them; expected error flags
// depend on whether IO_HUB_ERR_EN is defined.
module tb_io_port_hub;
  localparam int NUIOIN = 4;
  localparam int NUIOOU = 4;
  localparam int NBIN   = 19;
  localparam int NBOUT  = 28;
  localparam int FDEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  io_port_hub_if #(.NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .NBIN(NBIN), .NBOUT(NBOUT)) bus ();

  io_port_hub #(
    .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .NBIN(NBIN), .NBOUT(NBOUT), .FDEPTH(FDEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NBIN-1:0]  in_q[$];
  logic [NBOUT-1:0] out_q[$];
  logic [3:0]       exp_err = '0;
  logic [NBIN-1:0]  exp_in;
  logic [NBOUT-1:0] exp_out;

  function automatic logic [3:0] err_expect();
`ifdef IO_HUB_ERR_EN
    return exp_err;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic set_src(input int p, input logic [NBIN-1:0] d, input logic v);
    bus.src_data[p*NBIN +: NBIN] = d;
    bus.src_valid[p] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_in = '0; bus.out_en = '0; bus.io_out = '0;
    bus.src_data = '0; bus.src_valid = '0; bus.snk_ready = '0;
    @(negedge clk); #1;
    checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL reset_src_ready: got %b expected 1111", bus.src_ready); end
    checks++; if (bus.snk_valid !== 4'b0000) begin errors++; $display("FAIL reset_snk_valid: got %b expected 0000", bus.snk_valid); end
    checks++; if (bus.io_in !== '0) begin errors++; $display("FAIL reset_io_in: got %h expected 0", bus.io_in); end
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b expected 0000", bus.err); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_in_fifo();
    logic signed [NBIN-1:0] v[3];
    v[0] = 5; v[1] = -3; v[2] = 7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_src(1, v[i], 1'b1); in_q.push_back(v[i]);
      #1;
      checks++; if (bus.src_ready[1] !== 1'b1) begin errors++; $display("FAIL in_push_ready: got %b expected 1", bus.src_ready[1]); end
    end
    @(negedge clk); set_src(1, '0, 1'b0); bus.req_in = 4'b0010;
    repeat (3) begin
      #1; exp_in = in_q.pop_front();
      checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL in_read: got %h expected %h", bus.io_in, exp_in); end
      checks++; if (bus.src_ready[1] !== 1'b1) begin errors++; $display("FAIL in_read_ready: got %b expected 1", bus.src_ready[1]); end
      @(negedge clk);
    end
    bus.req_in = '0;
  endtask

  task automatic test_full();
    for (int i = 0; i < FDEPTH; i++) begin
      @(negedge clk); set_src(0, NBIN'(100 + i), 1'b1); in_q.push_back(NBIN'(100 + i));
      #1;
      checks++; if (bus.src_ready[0] !== 1'b1) begin errors++; $display("FAIL full_fill_ready: got %b expected 1", bus.src_ready[0]); end
    end
    @(negedge clk); set_src(0, NBIN'(99), 1'b1); #1;
    checks++; if (bus.src_ready[0] !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", bus.src_ready[0]); end
    @(negedge clk); set_src(0, '0, 1'b0); bus.req_in = 4'b0001; #1;
    exp_in = in_q.pop_front();
    checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL full_pop: got %h expected %h", bus.io_in, exp_in); end
    @(negedge clk); bus.req_in = '0; #1;
    checks++; if (bus.src_ready[0] !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", bus.src_ready[0]); end
    bus.req_in = 4'b0001;
    repeat (FDEPTH - 1) begin
      #1; exp_in = in_q.pop_front();
      checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL full_drain: got %h expected %h", bus.io_in, exp_in); end
      @(negedge clk);
    end
    bus.req_in = '0;
  endtask

  task automatic test_underflow();
    @(negedge clk); bus.req_in = 4'b0100; set_src(2, NBIN'('h12345), 1'b1); #1;
    exp_err[0] = 1'b1;
    checks++; if (bus.io_in !== '0) begin errors++; $display("FAIL uflow_io_in: got %h expected 0", bus.io_in); end
    @(negedge clk); bus.req_in = '0; set_src(2, '0, 1'b0); in_q.push_back(NBIN'('h12345)); #1;
    checks++; if (bus.err !== err_expect()) begin errors++; $display("FAIL uflow_err: got %b expected %b", bus.err, err_expect()); end
    @(negedge clk); bus.req_in = 4'b0100; #1;
    exp_in = in_q.pop_front();
    checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL uflow_no_bypass: got %h expected %h", bus.io_in, exp_in); end
    @(negedge clk); bus.req_in = '0; #1;
    checks++; if (bus.err !== err_expect()) begin errors++; $display("FAIL uflow_sticky: got %b expected %b", bus.err, err_expect()); end
  endtask

  task automatic test_multi_req();
    @(negedge clk); set_src(1, NBIN'('h111), 1'b1); set_src(2, NBIN'('h222), 1'b1);
    in_q.push_back(NBIN'('h111)); in_q.push_back(NBIN'('h222));
    @(negedge clk); set_src(1, '0, 1'b0); set_src(2, '0, 1'b0); bus.req_in = 4'b0110; #1;
    exp_err[2] = 1'b1;
    exp_in = in_q.pop_front();
    checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL mreq_low_port: got %h expected %h", bus.io_in, exp_in); end
    @(negedge clk); bus.req_in = 4'b0100; #1;
    exp_in = in_q.pop_front();
    checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL mreq_port2_kept: got %h expected %h", bus.io_in, exp_in); end
    @(negedge clk); bus.req_in = 4'b0010; #1;
    exp_err[0] = 1'b1;
    checks++; if (bus.io_in !== '0) begin errors++; $display("FAIL mreq_port1_empty: got %h expected 0", bus.io_in); end
    @(negedge clk); bus.req_in = '0; #1;
    checks++; if (bus.err !== err_expect()) begin errors++; $display("FAIL mreq_err: got %b expected %b", bus.err, err_expect()); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_src(3, NBIN'('h300), 1'b1); in_q.push_back(NBIN'('h300));
    @(negedge clk); set_src(3, NBIN'('h301), 1'b1); in_q.push_back(NBIN'('h301));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); set_src(3, NBIN'('h302 + i), 1'b1); in_q.push_back(NBIN'('h302 + i));
      bus.req_in = 4'b1000; #1;
      exp_in = in_q.pop_front();
      checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL b2b_read: got %h expected %h", bus.io_in, exp_in); end
      checks++; if (bus.src_ready[3] !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", bus.src_ready[3]); end
    end
    @(negedge clk); set_src(3, '0, 1'b0);
    repeat (2) begin
      #1; exp_in = in_q.pop_front();
      checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL b2b_drain: got %h expected %h", bus.io_in, exp_in); end
      @(negedge clk);
    end
    bus.req_in = '0;
  endtask

  task automatic test_out_fifo();
    bus.snk_ready = '0;
    for (int i = 0; i < FDEPTH + 1; i++) begin
      @(negedge clk);
      if (i == 1) begin
        #1;
        checks++; if (bus.snk_valid[3] !== 1'b1) begin errors++; $display("FAIL out_valid: got %b expected 1", bus.snk_valid[3]); end
        exp_out = out_q[0];
        checks++; if (bus.snk_data[3*NBOUT +: NBOUT] !== exp_out) begin errors++; $display("FAIL out_first_data: got %h expected %h", bus.snk_data[3*NBOUT +: NBOUT], exp_out); end
      end
      bus.out_en = 4'b1000;
      bus.io_out = (i == 0) ? NBOUT'('h0ABCDEF) : NBOUT'('h100 + i);
      if (i < FDEPTH) out_q.push_back(bus.io_out);
      else            exp_err[1] = 1'b1;
    end
    @(negedge clk); bus.out_en = '0; #1;
    checks++; if (bus.err !== err_expect()) begin errors++; $display("FAIL out_overflow_err: got %b expected %b", bus.err, err_expect()); end
    bus.snk_ready = 4'b1000;
    repeat (FDEPTH) begin
      #1; exp_out = out_q.pop_front();
      checks++; if (bus.snk_valid[3] !== 1'b1) begin errors++; $display("FAIL out_drain_valid: got %b expected 1", bus.snk_valid[3]); end
      checks++; if (bus.snk_data[3*NBOUT +: NBOUT] !== exp_out) begin errors++; $display("FAIL out_drain_data: got %h expected %h", bus.snk_data[3*NBOUT +: NBOUT], exp_out); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.snk_valid[3] !== 1'b0) begin errors++; $display("FAIL out_empty: got %b expected 0", bus.snk_valid[3]); end
    bus.snk_ready = '0;
  endtask

  task automatic test_multi_out();
    @(negedge clk); bus.out_en = 4'b1010; bus.io_out = NBOUT'('h55); out_q.push_back(NBOUT'('h55));
    exp_err[3] = 1'b1;
    @(negedge clk); bus.out_en = '0; #1;
    checks++; if (bus.snk_valid !== 4'b0010) begin errors++; $display("FAIL mout_valid: got %b expected 0010", bus.snk_valid); end
    exp_out = out_q.pop_front();
    checks++; if (bus.snk_data[NBOUT +: NBOUT] !== exp_out) begin errors++; $display("FAIL mout_data: got %h expected %h", bus.snk_data[NBOUT +: NBOUT], exp_out); end
    checks++; if (bus.err !== err_expect()) begin errors++; $display("FAIL mout_err: got %b expected %b", bus.err, err_expect()); end
    bus.snk_ready = 4'b0010;
    @(negedge clk); bus.snk_ready = '0; #1;
    checks++; if (bus.snk_valid !== 4'b0000) begin errors++; $display("FAIL mout_drained: got %b expected 0000", bus.snk_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); set_src(0, NBIN'('h1), 1'b1); bus.out_en = 4'b0001; bus.io_out = NBOUT'('h9);
    @(negedge clk); set_src(0, NBIN'('h2), 1'b1); bus.io_out = NBOUT'('ha);
    @(negedge clk); set_src(0, '0, 1'b0); bus.out_en = '0; #1;
    checks++; if (bus.snk_valid[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", bus.snk_valid[0]); end
    #1; rst = 1'b0; bus.req_in = 4'b0001; #1;
    exp_err = '0; in_q.delete(); out_q.delete();
    checks++; if (bus.snk_valid !== 4'b0000) begin errors++; $display("FAIL rmid_snk_valid: got %b expected 0000", bus.snk_valid); end
    checks++; if (bus.src_ready !== 4'b1111) begin errors++; $display("FAIL rmid_src_ready: got %b expected 1111", bus.src_ready); end
    checks++; if (bus.io_in !== '0) begin errors++; $display("FAIL rmid_io_in: got %h expected 0", bus.io_in); end
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL rmid_err: got %b expected 0000", bus.err); end
    @(negedge clk); bus.req_in = '0; rst = 1'b1;
    @(negedge clk); set_src(0, NBIN'('h777), 1'b1); in_q.push_back(NBIN'('h777));
    @(negedge clk); set_src(0, '0, 1'b0); bus.req_in = 4'b0001; #1;
    exp_in = in_q.pop_front();
    checks++; if (bus.io_in !== exp_in) begin errors++; $display("FAIL rmid_first_word: got %h expected %h", bus.io_in, exp_in); end
    @(negedge clk); bus.req_in = '0;
  endtask

  initial begin
    test_reset();
    test_in_fifo();
    test_full();
    test_underflow();
    test_multi_req();
    test_back_to_back();
    test_out_fifo();
    test_multi_out();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
